// File: rtl/prog_loader_fetch.sv
// Instruction memory with a UART byte-stream loader and a registered fetch port.
// LOAD mode: 4-byte word-count header followed by the program words.
// EXEC mode: one instruction per fetch request, one-cycle latency.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for mode=1
// HDR   | collecting the 4-byte word count
// DATA  | collecting program words and writing them into memory
// DONE  | program loaded; fetches served while mode=0
// ERR   | header count exceeded memory depth; waits for mode=0
module prog_loader_fetch #(
    parameter int          ADDR_W     = 10,
    parameter int          DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mode,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [31:0]       pc,
    input  logic              fetch_req,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              fetch_fault,
    output logic              done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int                BYTES = DATA_W / 8;
    localparam logic [32:0]       DEPTH = 33'd1 << ADDR_W;
    localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INST);
    localparam logic [ADDR_W:0]   ONE   = 1;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [3:0]        byte_cnt;
    logic [31:0]       hdr_sr, hdr_nxt;
    logic [DATA_W-1:0] word_sr, word_nxt;
    logic [ADDR_W:0]   n_words;
    logic              mode_q;
    logic              hdr_last, word_last, enter_hdr;
    logic              hdr_zero, hdr_big;
    logic [31:0]       idx_full;
    logic              fault_nxt, fetch_en;

    assign hdr_zero = (hdr_nxt == 32'd0);
    assign hdr_big  = ({1'b0, hdr_nxt} > DEPTH);

    // Byte assembly: shift the incoming byte into header/word in the configured order.
    always_comb begin
        hdr_nxt  = 32'd0;
        word_nxt = '0;
        if (BIG_ENDIAN) begin
            hdr_nxt        = hdr_sr << 8;
            hdr_nxt[7:0]   = rx_data;
            word_nxt       = word_sr << 8;
            word_nxt[7:0]  = rx_data;
        end else begin
            hdr_nxt                = hdr_sr >> 8;
            hdr_nxt[31:24]         = rx_data;
            word_nxt               = word_sr >> 8;
            word_nxt[DATA_W-1 -: 8] = rx_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and loader strobes; mode=0 aborts an in-progress load.
    always_comb begin
        state_nxt = state;
        hdr_last  = 1'b0;
        word_last = 1'b0;
        enter_hdr = 1'b0;
        case (state)
            S_IDLE: begin
                if (mode) begin
                    state_nxt = S_HDR;
                    enter_hdr = 1'b1;
                end
            end
            S_HDR: begin
                if (!mode) begin
                    state_nxt = S_IDLE;
                end else if (rx_valid && byte_cnt == 4'd3) begin
                    hdr_last = 1'b1;
                    if (hdr_zero)     state_nxt = S_DONE;
                    else if (hdr_big) state_nxt = S_ERR;
                    else              state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (!mode) begin
                    state_nxt = S_IDLE;
                end else if (rx_valid && byte_cnt == 4'(BYTES - 1)) begin
                    word_last = 1'b1;
                    if ((words_loaded + ONE) == n_words) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Reload only on a fresh 0->1 edge, not while LOAD is still held.
                if (mode && !mode_q) begin
                    state_nxt = S_HDR;
                    enter_hdr = 1'b1;
                end
            end
            S_ERR: begin
                if (!mode) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Loader datapath: byte counter, header/word shift registers, status flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_cnt     <= 4'd0;
            hdr_sr       <= 32'd0;
            word_sr      <= '0;
            n_words      <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            load_err     <= 1'b0;
            mode_q       <= 1'b0;
        end else begin
            mode_q <= mode;
            if (enter_hdr) begin
                byte_cnt     <= 4'd0;
                words_loaded <= '0;
                done         <= 1'b0;
                load_err     <= 1'b0;
            end
            if ((state == S_HDR || state == S_DATA) && !mode) begin
                byte_cnt <= 4'd0;
            end
            if (state == S_HDR && mode && rx_valid) begin
                hdr_sr   <= hdr_nxt;
                byte_cnt <= hdr_last ? 4'd0 : byte_cnt + 4'd1;
            end
            if (hdr_last) begin
                if (hdr_zero)     done     <= 1'b1;
                else if (hdr_big) load_err <= 1'b1;
                else              n_words  <= hdr_nxt[ADDR_W:0];
            end
            if (state == S_DATA && mode && rx_valid) begin
                word_sr  <= word_nxt;
                byte_cnt <= word_last ? 4'd0 : byte_cnt + 4'd1;
            end
            if (word_last) begin
                words_loaded <= words_loaded + ONE;
                if (state_nxt == S_DONE) done <= 1'b1;
            end
            if (state == S_ERR && !mode) begin
                load_err <= 1'b0;
            end
        end
    end

    // Memory write port, driven by the loader on the last byte of each word.
    always_ff @(posedge clk) begin
        if (word_last) mem[words_loaded[ADDR_W-1:0]] <= word_nxt;
    end

    assign fetch_en  = fetch_req && !mode && done;
    assign idx_full  = pc / 32'(BYTES);
    assign fault_nxt = ((pc % 32'(BYTES)) != 32'd0)
                     || ((idx_full >> ADDR_W) != 32'd0)
                     || ({1'b0, idx_full[ADDR_W-1:0]} >= words_loaded);

    // Registered fetch port; inst holds when no request is accepted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inst        <= '0;
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            inst_valid <= fetch_en;
            if (fetch_en) begin
                fetch_fault <= fault_nxt;
                inst        <= fault_nxt ? NOP_W : mem[idx_full[ADDR_W-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_prog_loader_fetch.sv
// Bench for prog_loader_fetch: a big-endian 1024-word instance and a
// little-endian 16-word instance, a transaction-level model and a fetch scoreboard.
module tb_prog_loader_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        mode0, rxv0, freq0, iv0, ff0, done0, err0;
    logic [7:0]  rxd0;
    logic [31:0] pc0, inst0;
    logic [10:0] wl0;
    logic        mode1, rxv1, freq1, iv1, ff1, done1, err1;
    logic [7:0]  rxd1;
    logic [31:0] pc1, inst1;
    logic [4:0]  wl1;

    prog_loader_fetch #(.ADDR_W(10), .DATA_W(32), .BIG_ENDIAN(1'b1), .NOP_INST(NOP)) u_be (
        .clk(clk), .rstn(rstn), .mode(mode0), .rx_valid(rxv0), .rx_data(rxd0),
        .pc(pc0), .fetch_req(freq0), .inst(inst0), .inst_valid(iv0),
        .fetch_fault(ff0), .done(done0), .load_err(err0), .words_loaded(wl0));

    prog_loader_fetch #(.ADDR_W(4), .DATA_W(32), .BIG_ENDIAN(1'b0), .NOP_INST(NOP)) u_le (
        .clk(clk), .rstn(rstn), .mode(mode1), .rx_valid(rxv1), .rx_data(rxd1),
        .pc(pc1), .fetch_req(freq1), .inst(inst1), .inst_valid(iv1),
        .fetch_fault(ff1), .done(done1), .load_err(err1), .words_loaded(wl1));

    typedef struct packed { int due; logic fault; logic [31:0] inst; } exp_t;
    exp_t q0[$], q1[$];

    // Reference model: what the loader has stored, per instance.
    logic [31:0] m_mem [2][1024];
    int          m_wl [2];
    bit          m_done [2], m_err [2], m_mode [2];
    logic [31:0] m_last [2];
    logic [31:0] prog[$];

    int checks = 0, errors = 0;

    function automatic int depth_of(input int d);
        return (d == 0) ? 1024 : 16;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input int d, input string tag);
        if (d == 0) begin
            chk($sformatf("%s done0", tag), 64'(done0), 64'(m_done[0]));
            chk($sformatf("%s load_err0", tag), 64'(err0), 64'(m_err[0]));
            chk($sformatf("%s words_loaded0", tag), 64'(wl0), 64'(m_wl[0]));
        end else begin
            chk($sformatf("%s done1", tag), 64'(done1), 64'(m_done[1]));
            chk($sformatf("%s load_err1", tag), 64'(err1), 64'(m_err[1]));
            chk($sformatf("%s words_loaded1", tag), 64'(wl1), 64'(m_wl[1]));
        end
    endtask

    task automatic check_reset(input int d);
        if (d == 0) begin
            chk("rst inst0", 64'(inst0), 64'd0);
            chk("rst inst_valid0", 64'(iv0), 64'd0);
            chk("rst fetch_fault0", 64'(ff0), 64'd0);
        end else begin
            chk("rst inst1", 64'(inst1), 64'd0);
            chk("rst inst_valid1", 64'(iv1), 64'd0);
            chk("rst fetch_fault1", 64'(ff1), 64'd0);
        end
        check_status(d, "rst");
    endtask

    task automatic drive_rx(input int d, input logic v, input logic [7:0] b);
        if (d == 0) begin rxv0 = v; rxd0 = b; end
        else        begin rxv1 = v; rxd1 = b; end
    endtask

    task automatic send_byte(input int d, input logic [7:0] b);
        @(posedge clk); #1; drive_rx(d, 1'b1, b);
        @(posedge clk); #1; drive_rx(d, 1'b0, 8'h00);
    endtask

    task automatic set_mode(input int d, input logic v);
        @(posedge clk); #1;
        if (d == 0) mode0 = v; else mode1 = v;
        m_mode[d] = v;
        if (v) begin m_wl[d] = 0; m_done[d] = 0; m_err[d] = 0; end
        else   m_err[d] = 0;
        @(posedge clk); #1;
    endtask

    // Full or partial load of the words in prog; nbytes data bytes are sent.
    task automatic load(input int d, input logic [31:0] n, input int nbytes);
        logic [31:0] w;
        logic [7:0]  b;
        set_mode(d, 1'b1);
        for (int i = 0; i < 4; i++) begin
            b = (d == 0) ? 8'(n >> (8 * (3 - i))) : 8'(n >> (8 * i));
            send_byte(d, b);
        end
        if (n == 0) m_done[d] = 1;
        else if (n > 32'(depth_of(d))) m_err[d] = 1;
        check_status(d, "hdr");
        for (int i = 0; i < nbytes; i++) begin
            w = (i / 4 < prog.size()) ? prog[i / 4] : 32'hA5A5_A5A5;
            b = (d == 0) ? 8'(w >> (8 * (3 - i % 4))) : 8'(w >> (8 * (i % 4)));
            send_byte(d, b);
            if (i % 4 == 3 && n != 0 && !m_err[d] && !m_done[d]) begin
                m_mem[d][i / 4] = w;
                m_wl[d]         = i / 4 + 1;
                m_done[d]       = (32'(m_wl[d]) == n);
                check_status(d, "word");
            end
        end
        if (m_err[d] || n == 0) check_status(d, "ignored");
    endtask

    task automatic fetch(input int d, input logic [31:0] a);
        exp_t        e;
        logic [31:0] idx;
        @(posedge clk); #1;
        if (d == 0) begin freq0 = 1'b1; pc0 = a; end
        else        begin freq1 = 1'b1; pc1 = a; end
        if (!m_mode[d] && m_done[d]) begin
            idx     = a / 4;
            e.due   = cyc + 1;
            e.fault = (a % 4 != 0) || (idx >= 32'(depth_of(d))) || (idx >= 32'(m_wl[d]));
            e.inst  = e.fault ? NOP : m_mem[d][idx[9:0]];
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic fetch_stop(input int d);
        @(posedge clk); #1;
        if (d == 0) begin freq0 = 1'b0; pc0 = $urandom; end
        else        begin freq1 = 1'b0; pc1 = $urandom; end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        @(posedge clk); #1;
        rstn = 1'b0;
        mode0 = 0; mode1 = 0; freq0 = 0; freq1 = 0; rxv0 = 0; rxv1 = 0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_wl[d] = 0; m_done[d] = 0; m_err[d] = 0; m_last[d] = 32'd0;
        end
        check_reset(0);
        check_reset(1);
        q0.delete();
        q1.delete();
        rstn = 1'b1;
    endtask

    task automatic mon(input int d, input logic v, input logic f, input logic [31:0] i);
        exp_t e;
        bit   have;
        have = 0;
        if (d == 0) begin
            while (q0.size() > 0 && q0[0].due < cyc) begin
                void'(q0.pop_front());
                checks++; errors++;
                $display("FAIL missed response dut0 at cycle %0d", cyc);
            end
            if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1; end
        end else begin
            while (q1.size() > 0 && q1[0].due < cyc) begin
                void'(q1.pop_front());
                checks++; errors++;
                $display("FAIL missed response dut1 at cycle %0d", cyc);
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1; end
        end
        chk($sformatf("inst_valid%0d", d), 64'(v), 64'(have));
        if (have && v) begin
            chk($sformatf("fetch_fault%0d", d), 64'(f), 64'(e.fault));
            chk($sformatf("inst%0d", d), 64'(i), 64'(e.inst));
            m_last[d] = e.inst;
        end else if (!v) begin
            chk($sformatf("inst_hold%0d", d), 64'(i), 64'(m_last[d]));
        end
    endtask

    // Monitor: compares every non-reset cycle against the scoreboard queues.
    always @(negedge clk) begin
        if (rstn) begin
            mon(0, iv0, ff0, inst0);
            mon(1, iv1, ff1, inst1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          d, n, sel;
        rstn = 0; mode0 = 0; mode1 = 0; rxv0 = 0; rxv1 = 0; freq0 = 0; freq1 = 0;
        rxd0 = 0; rxd1 = 0; pc0 = 0; pc1 = 0;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_wl[k] = 0; m_done[k] = 0; m_err[k] = 0; m_last[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rstn = 1;

        // Three-word big-endian program, then back-to-back fetches and faulting PCs.
        prog = '{32'h1122_3344, 32'h5566_7788, 32'h0000_003F};
        load(0, 32'd3, 12);
        set_mode(0, 1'b0);
        fetch(0, 32'd0); fetch(0, 32'd4); fetch(0, 32'd8);
        fetch(0, 32'd12); fetch(0, 32'd2); fetch(0, 32'h0001_0000); fetch(0, 32'h0000_1000);
        fetch_stop(0);

        // Little-endian instance: header 02 00 00 00, first word bytes 44 33 22 11.
        prog = '{32'h1122_3344, 32'hCAFE_BABE};
        load(1, 32'd2, 8);
        set_mode(1, 1'b0);
        fetch(1, 32'd0); fetch(1, 32'd4); fetch(1, 32'd8);
        fetch_stop(1);

        // Oversized header: error, following bytes ignored, fetch ignored.
        load(0, 32'd1025, 8);
        set_mode(0, 1'b0);
        check_status(0, "err_clear");
        fetch(0, 32'd0);
        fetch_stop(0);

        // Zero-length program.
        load(0, 32'd0, 0);
        set_mode(0, 1'b0);
        fetch(0, 32'd0);
        fetch_stop(0);

        // Depth boundary on the 16-word instance.
        prog.delete();
        for (int i = 0; i < 16; i++) prog.push_back($urandom);
        load(1, 32'd16, 64);
        set_mode(1, 1'b0);
        fetch(1, 32'd60); fetch(1, 32'd64); fetch(1, 32'd0);
        fetch_stop(1);
        load(1, 32'd17, 4);
        set_mode(1, 1'b0);
        check_status(1, "err17_clear");

        // Abort mid-word, then reload.
        prog = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1, 32'h2};
        load(0, 32'd4, 6);
        set_mode(0, 1'b0);
        check_status(0, "abort");
        fetch(0, 32'd0);
        fetch_stop(0);
        prog = '{32'h7654_3210};
        load(0, 32'd1, 4);
        check_status(0, "reload");
        set_mode(0, 1'b0);
        fetch(0, 32'd0); fetch(0, 32'd4);
        fetch_stop(0);

        // Reset in the middle of DATA.
        prog = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        load(0, 32'd5, 9);
        reset_all();
        fetch(0, 32'd0);
        fetch_stop(0);

        // Randomized programs and fetch addresses.
        for (int r = 0; r < 6; r++) begin
            d = r % 2;
            n = (d == 0) ? int'($urandom_range(1, 24)) : int'($urandom_range(1, 16));
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            load(d, 32'(n), 4 * n);
            set_mode(d, 1'b0);
            for (int k = 0; k < 30; k++) begin
                sel = int'($urandom_range(0, 5));
                case (sel)
                    0:       a = 32'($urandom_range(0, n) * 4 + $urandom_range(1, 3));
                    1:       a = 32'(depth_of(d) * 4) + 32'($urandom_range(0, 64) * 4);
                    2:       a = $urandom;
                    default: a = 32'($urandom_range(0, n + 2) * 4);
                endcase
                fetch(d, a);
            end
            fetch_stop(d);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("q0 drained", 64'(q0.size()), 64'd0);
        chk("q1 drained", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
